// File: rtl/hamming_pkg.sv
// hamming_pkg
// Shared widths, the control state encoding and the parity masks for the
// serial Hamming(15,11) encoder.
//   DATA_W / PAR_W / CODE_W : message, parity and code word widths
//   CNT_W                   : width of the shared receive/send bit counter
//   state_t                 : RECV -> CALC -> SEND -> DONE
//   PAR_MASK                : data bits covered by p1, p2, p4, p8 (index 0..3)
package hamming_pkg;

   localparam int DATA_W = 11;
   localparam int PAR_W  = 4;
   localparam int CODE_W = 15;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      RECV = 2'd0,
      CALC = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

   // Row j selects the data bits whose Hamming position has bit j set.
   // Data bit i sits at position 3,5,6,7,9,10,11,12,13,14,15.
   localparam logic [PAR_W-1:0][DATA_W-1:0] PAR_MASK = {
      11'b111_1111_0000,   // p8: d4..d10
      11'b111_1000_1110,   // p4: d1 d2 d3 d7 d8 d9 d10
      11'b110_0110_1101,   // p2: d0 d2 d3 d5 d6 d9 d10
      11'b101_0101_1011    // p1: d0 d1 d3 d4 d6 d8 d10
   };

endpackage

// File: rtl/hamming_parity.sv
// hamming_parity
// Purely combinational 11-to-4 Hamming parity generator.
//   data : message bits d0..d10 (bit i = di)
//   par  : {p8, p4, p2, p1}
module hamming_parity
   import hamming_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   output logic [PAR_W-1:0]  par
);

   genvar gi;
   generate
      for (gi = 0; gi < PAR_W; gi = gi + 1) begin : g_par
         assign par[gi] = ^(data & PAR_MASK[gi]);
      end
   endgenerate

endmodule

// File: rtl/hamming_core.sv
// hamming_core
// Serial Hamming(15,11) encoder. Shifts in 11 data bits LSB first, computes
// parity in one cycle, then streams d0..d10 followed by p1, p2, p4, p8.
// After the word the block idles with out=0 until the next reset.
//   clk : clock, all state on the rising edge
//   rst : synchronous active-high reset; aborts any operation in progress
//   inp : serial message input, LSB first
//   out : serial code word output, registered
module hamming_core
   import hamming_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic inp,
   output logic out
);

   state_t              state_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic [DATA_W-1:0]   data_reg;
   logic [PAR_W-1:0]    par_reg;
   logic                out_reg;

   logic [PAR_W-1:0]    par_calc;
   logic [CODE_W-1:0]   code_word;

   hamming_parity u_parity (
      .data (data_reg),
      .par  (par_calc)
   );

   // Code bit k is transmitted k-th, so parity lands in the top nibble.
   assign code_word = {par_reg, data_reg};
   assign out       = out_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= RECV;
         cnt_reg   <= '0;
         data_reg  <= '0;
         par_reg   <= '0;
         out_reg   <= 1'b0;
      end else begin
         case (state_reg)
            RECV: begin
               out_reg           <= 1'b0;
               data_reg[cnt_reg] <= inp;
               if (cnt_reg == CNT_W'(DATA_W - 1)) begin
                  cnt_reg   <= '0;
                  state_reg <= CALC;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            CALC: begin
               out_reg   <= 1'b0;
               par_reg   <= par_calc;
               cnt_reg   <= '0;
               state_reg <= SEND;
            end
            SEND: begin
               out_reg <= code_word[cnt_reg];
               if (cnt_reg == CNT_W'(CODE_W - 1)) begin
                  cnt_reg   <= '0;
                  state_reg <= DONE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            DONE: begin
               out_reg <= 1'b0;
            end
            default: begin
               out_reg   <= 1'b0;
               cnt_reg   <= '0;
               state_reg <= RECV;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hamming_core.sv
// tb_hamming_core
// Directed and random stimulus for hamming_core. Expected code bits are pushed
// to a scoreboard queue when a message is driven and popped as the DUT
// streams them out.
module tb_hamming_core;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic inp = 1'b0;
   logic out;

   int checks   = 0;
   int failures = 0;

   logic sb[$];

   hamming_core dut (
      .clk (clk),
      .rst (rst),
      .inp (inp),
      .out (out)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   // Hamming position of each transmitted code bit.
   function automatic logic [3:0] code_pos(input int k);
      int pos_tab[15] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 1, 2, 4, 8};
      return pos_tab[k][3:0];
   endfunction

   // Parity nibble is the XOR of the positions of all set data bits.
   function automatic logic [14:0] model_code(input logic [10:0] d);
      logic [3:0] p;
      p = 4'b0;
      for (int i = 0; i < 11; i++)
         if (d[i]) p = p ^ code_pos(i);
      return {p, d};
   endfunction

   function automatic logic [3:0] syndrome(input logic [14:0] c);
      logic [3:0] s;
      s = 4'b0;
      for (int k = 0; k < 15; k++)
         if (c[k]) s = s ^ code_pos(k);
      return s;
   endfunction

   task automatic check_bit(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   task automatic check_vec(input string tag, input logic [14:0] obs, input logic [14:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic apply_reset(input int n);
      for (int i = 0; i < n; i++) begin
         rst = 1'b1;
         inp = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         check_bit("reset_out", out, 1'b0);
      end
      rst = 1'b0;
   endtask

   // Drives one message and checks the first nsend streamed bits.
   task automatic send_msg(input logic [10:0] d, input logic [14:0] exp_code,
                           input int nsend, output logic [14:0] got);
      logic expb;
      got = '0;
      for (int k = 0; k < nsend; k++) sb.push_back(exp_code[k]);
      for (int i = 0; i < 11; i++) begin
         inp = d[i];
         @(posedge clk);
         #1;
         check_bit("recv_out", out, 1'b0);
      end
      inp = ~d[0];
      @(posedge clk);
      #1;
      check_bit("calc_out", out, 1'b0);
      for (int k = 0; k < nsend; k++) begin
         inp = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         expb = sb.pop_front();
         check_bit($sformatf("send_bit%0d", k), out, expb);
         got[k] = out;
      end
      if (nsend == 15) begin
         @(posedge clk);
         #1;
         check_bit("done_out", out, 1'b0);
      end
      $display("msg data=%b sent=%0d code=%b", d, nsend, got);
   endtask

   initial begin
      logic [14:0] got;
      logic [10:0] d;

      // Long reset, then the first reference vector.
      apply_reset(5);
      send_msg(11'b01010010011, 15'b110101010010011, 15, got);
      check_vec("code_v1", got, 15'b110101010010011);

      apply_reset(1);
      send_msg(11'b00000000110, 15'b001100000000110, 15, got);
      apply_reset(1);
      send_msg(11'b00000000011, 15'b011000000000011, 15, got);
      apply_reset(1);
      send_msg(11'b11110000000, 15'b000011110000000, 15, got);
      check_vec("parity_zero", {11'b0, got[14:11]}, 15'b0);
      apply_reset(1);
      send_msg(11'b11111111100, 15'b100111111111100, 15, got);

      // Abort mid-SEND, then a fresh word must be clean.
      apply_reset(1);
      send_msg(11'b11111111111, model_code(11'b11111111111), 6, got);
      apply_reset(1);
      send_msg(11'b00011100011, 15'b101100011100011, 15, got);

      // DONE ignores inp.
      for (int i = 0; i < 20; i++) begin
         inp = ~inp;
         @(posedge clk);
         #1;
         check_bit("done_hold", out, 1'b0);
      end

      // Abort mid-RECV with multi-cycle reset.
      apply_reset(1);
      for (int i = 0; i < 6; i++) begin
         inp = 1'b1;
         @(posedge clk);
         #1;
      end
      apply_reset(3);
      send_msg(11'b00000100000, model_code(11'b00000100000), 15, got);

      // Random words: stream must match the model and be a valid code word.
      for (int n = 0; n < 40; n++) begin
         d = 11'($urandom_range(0, 2047));
         apply_reset(1);
         send_msg(d, model_code(d), 15, got);
         check_vec("syndrome", {11'b0, syndrome(got)}, 15'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
